mult_alu_sched: RTL

Sequencer for the execute stage's iterative 32x32 multiplier. It shares the single execute-stage ALU between the pipeline and the multiplier: the block borrows the ALU adder for 32 shift-add steps, then owns the HI/LO result registers. It also raises the execute-stage stall that the hazard unit uses to freeze F/D/E while the ALU is borrowed. It sits between the E pipeline register outputs and the ALU input muxes.

---
 rtl/mult_alu_sched.sv | 139 +++++++++++++
 1 files changed

// File: rtl/mult_alu_sched.sv
// Iterative 32x32 multiply sequencer that borrows the execute-stage ALU adder for shift-add steps.
// Latency: start sampled at edge 0, 32 RUN cycles + 1 FIN cycle, done pulses in cycle 34.
// Backpressure: none accepted; raises stall_e for the whole borrow so the pipeline holds F/D/E.
module mult_alu_sched (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        sgn,
    input  logic [31:0] srca,
    input  logic [31:0] srcb,
    output logic        alu_sel_mult,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [2:0]  alu_f,
    input  logic [31:0] alu_y,
    output logic        stall_e,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    localparam logic [2:0] ALU_ADD = 3'b010;

    state_t      state;
    state_t      nextState;
    logic [31:0] acc;
    logic [31:0] mplr;
    logic [31:0] mcand;
    logic [4:0]  cnt;
    logic        neg;
    logic        carry;
    logic [31:0] magA;
    logic [31:0] magB;
    logic [63:0] rawProd;
    logic [63:0] finProd;

    // Operand magnitudes; 0x80000000 negates to itself, which is the correct unsigned magnitude.
    assign magA    = (sgn && srca[31]) ? (~srca + 32'd1) : srca;
    assign magB    = (sgn && srcb[31]) ? (~srcb + 32'd1) : srcb;

    // Adder carry-out recovered from the borrowed ALU: sum wrapped below the accumulator.
    assign carry   = (alu_y < acc);

    // Final sign fix-up applied across the full 64-bit product.
    assign rawProd = {acc, mplr};
    assign finProd = neg ? (~rawProd + 64'd1) : rawProd;

    // State register; reset drops straight to IDLE so stall and ALU ownership release at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state and ALU-borrow outputs; ALU operands are zeroed whenever the pipeline owns it.
    always_comb begin
        nextState    = state;
        alu_sel_mult = 1'b0;
        alu_a        = 32'd0;
        alu_b        = 32'd0;
        alu_f        = 3'b000;
        stall_e      = 1'b0;
        busy         = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    nextState = RUN;
                end
            end
            RUN: begin
                alu_sel_mult = 1'b1;
                alu_a        = acc;
                alu_b        = mplr[0] ? mcand : 32'd0;
                alu_f        = ALU_ADD;
                stall_e      = 1'b1;
                busy         = 1'b1;
                if (cnt == 5'd31) begin
                    nextState = FIN;
                end
            end
            FIN: begin
                stall_e   = 1'b1;
                busy      = 1'b1;
                nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    // Datapath: latch magnitudes on start, shift-add during RUN, write signed result in FIN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc   <= 32'd0;
            mplr  <= 32'd0;
            mcand <= 32'd0;
            cnt   <= 5'd0;
            neg   <= 1'b0;
            hi    <= 32'd0;
            lo    <= 32'd0;
            done  <= 1'b0;
        end else begin
            done <= (state == FIN);
            unique case (state)
                IDLE: begin
                    if (start) begin
                        mcand <= magA;
                        mplr  <= magB;
                        neg   <= sgn & (srca[31] ^ srcb[31]);
                        acc   <= 32'd0;
                        cnt   <= 5'd0;
                    end
                end
                RUN: begin
                    acc  <= {carry, alu_y[31:1]};
                    mplr <= {alu_y[0], mplr[31:1]};
                    cnt  <= cnt + 5'd1;
                end
                FIN: begin
                    hi <= finProd[63:32];
                    lo <= finProd[31:0];
                end
                default: begin
                end
            endcase
        end
    end

endmodule
